clkdiv_rstgen: RTL and testbench

Parametrised system-clock divider and reset sequencer for SAKURA-G control and main FPGA designs. It divides a PLL output clock by a runtime-selectable ratio. Ratio changes are applied glitch-free, only at full-period boundaries. It releases a synchronous downstream reset only after PLL lock plus a programmable number of divided-clock periods, and re-asserts that reset on lock loss. It sits between the PLL and the BUFH that drives the local-bus and cipher-interface clock.

---
 rtl/clkdiv_rstgen.sv | 126 ++++++++++++
 tb/tb_clkdiv_rstgen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_rstgen.sv
// clkdiv_rstgen: PLL clock divider with glitch-free ratio change and a
// lock-gated reset sequencer. Define CLKDIV_SEL_SYNC_EN to sync div_sel.
module clkdiv_rstgen #(
  parameter int unsigned      DIV_W      = 4,
  parameter logic [DIV_W-1:0] RESET_DIV  = {DIV_W{1'b1}},
  parameter int unsigned      RST_CYCLES = 255
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             locked,
  input  logic [DIV_W-1:0] div_sel,
  output logic             div_clk,
  output logic             div_rise,
  output logic             rstn_out,
  output logic [DIV_W-1:0] cur_div
);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    HOLD,
    RUN
  } state_e;

  localparam logic [15:0] RST_N = 16'(RST_CYCLES);

  logic [DIV_W-1:0] sel_s;

`ifdef CLKDIV_SEL_SYNC_EN
  logic [DIV_W-1:0] sync1_q;
  logic [DIV_W-1:0] sync2_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= RESET_DIV;
      sync2_q <= RESET_DIV;
    end else begin
      sync1_q <= div_sel;
      sync2_q <= sync1_q;
    end
  end

  assign sel_s = sync2_q;
`else
  assign sel_s = div_sel;
`endif

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic             div_clk_q, div_clk_d;
  logic             div_rise_q, div_rise_d;
  logic             wrap;
  logic             rise;

  // Ratio is only swapped on the low->high toggle, so every phase is whole.
  always_comb begin
    wrap       = (cnt_q == cur_div_q);
    rise       = wrap & ~div_clk_q;
    cnt_d      = wrap ? '0 : cnt_q + 1'b1;
    div_clk_d  = div_clk_q ^ wrap;
    div_rise_d = rise;
    cur_div_d  = rise ? sel_s : cur_div_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q      <= '0;
      div_clk_q  <= 1'b0;
      div_rise_q <= 1'b0;
      cur_div_q  <= RESET_DIV;
    end else begin
      cnt_q      <= cnt_d;
      div_clk_q  <= div_clk_d;
      div_rise_q <= div_rise_d;
      cur_div_q  <= cur_div_d;
    end
  end

  state_e      state_q;
  logic [15:0] hcnt_q;
  logic        rstn_q;

  // Lock loss overrides everything, including a pending div_rise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= WAIT_LOCK;
      hcnt_q  <= '0;
      rstn_q  <= 1'b0;
    end else if (!locked) begin
      state_q <= WAIT_LOCK;
      hcnt_q  <= '0;
      rstn_q  <= 1'b0;
    end else begin
      unique case (state_q)
        WAIT_LOCK: begin
          state_q <= HOLD;
          hcnt_q  <= '0;
          rstn_q  <= 1'b0;
        end
        HOLD: begin
          rstn_q <= 1'b0;
          if (div_rise_q && hcnt_q != RST_N) begin
            hcnt_q <= hcnt_q + 16'd1;
            if (hcnt_q + 16'd1 == RST_N) begin
              state_q <= RUN;
              rstn_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          rstn_q <= 1'b1;
        end
        default: begin
          state_q <= WAIT_LOCK;
          hcnt_q  <= '0;
          rstn_q  <= 1'b0;
        end
      endcase
    end
  end

  assign div_clk  = div_clk_q;
  assign div_rise = div_rise_q;
  assign rstn_out = rstn_q;
  assign cur_div  = cur_div_q;

endmodule

// File: tb/tb_clkdiv_rstgen.sv
// tb_clkdiv_rstgen: scoreboarded bench for clkdiv_rstgen; edges and
// reset transitions are queued with hand-computed cycle numbers.
module tb_clkdiv_rstgen;

`ifdef CLKDIV_SEL_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       locked = 1'b0;
  logic [3:0] div_sel = 4'd7;
  logic       div_clk;
  logic       div_rise;
  logic       rstn_out;
  logic [3:0] cur_div;

  typedef struct {
    int cyc;
    bit val;
    int dv;
  } ev_t;

  ev_t clk_q[$];
  ev_t rst_q[$];
  int  n_chk = 0;
  int  n_fail = 0;
  int  cyc = 0;
  bit  p_clk = 1'b0;
  bit  p_rstn = 1'b0;

  clkdiv_rstgen #(
    .DIV_W     (4),
    .RESET_DIV (4'd7),
    .RST_CYCLES(4)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .locked  (locked),
    .div_sel (div_sel),
    .div_clk (div_clk),
    .div_rise(div_rise),
    .rstn_out(rstn_out),
    .cur_div (cur_div)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic push_clk(input int c, input bit v, input int d);
    clk_q.push_back('{cyc: c, val: v, dv: d});
  endtask

  task automatic push_rst(input int c, input bit v);
    rst_q.push_back('{cyc: c, val: v, dv: 0});
  endtask

  task automatic wait_cyc(input int n);
    int g;
    g = 0;
    while (cyc < n && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (cyc < n) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_cyc: got %0d, expected %0d", cyc, n);
    end
  endtask

  // Monitor: pops the expected edge whenever an output transitions.
  always @(negedge clk) begin
    if (!resetn) begin
      p_clk  <= 1'b0;
      p_rstn <= 1'b0;
    end else begin
      chk("div_rise_pulse", div_rise, div_clk && !p_clk);
      if (div_clk != p_clk) begin
        if (clk_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL edge_unexpected: got div_clk=%0d, expected no edge (cycle %0d)",
                   div_clk, cyc);
        end else begin
          chk("edge_cycle", cyc, clk_q[0].cyc);
          chk("edge_dir", div_clk, clk_q[0].val);
          if (div_clk) chk("cur_div", cur_div, clk_q[0].dv);
          void'(clk_q.pop_front());
        end
      end
      if (rstn_out != p_rstn) begin
        if (rst_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rstn_unexpected: got rstn_out=%0d, expected no change (cycle %0d)",
                   rstn_out, cyc);
        end else begin
          chk("rstn_cycle", cyc, rst_q[0].cyc);
          chk("rstn_value", rstn_out, rst_q[0].val);
          void'(rst_q.pop_front());
        end
      end
      p_clk  <= div_clk;
      p_rstn <= rstn_out;
    end
  end

  initial begin
    int r;
    resetn  = 1'b0;
    locked  = 1'b1;
    div_sel = 4'd7;
    repeat (3) @(negedge clk);
    chk("reset_div_clk", div_clk, 0);
    chk("reset_div_rise", div_rise, 0);
    chk("reset_rstn_out", rstn_out, 0);
    chk("reset_cur_div", cur_div, 7);

    r = 92 + SYNC_LAT;
    for (int k = 0; k < 4; k++) begin
      push_clk(8 + 16 * k, 1'b1, 7);
      push_clk(16 + 16 * k, 1'b0, 7);
    end
    for (int c = 72; c < r; c += 2) begin
      push_clk(c, 1'b1, 0);
      push_clk(c + 1, 1'b0, 0);
    end
    push_clk(r, 1'b1, 15);
    push_clk(r + 16, 1'b0, 15);
    push_clk(r + 32, 1'b1, 15);
    push_clk(r + 48, 1'b0, 15);
    push_clk(r + 64, 1'b1, 15);
    push_rst(57, 1'b1);
    push_rst(80, 1'b0);
    push_rst(89, 1'b1);

    #2 resetn = 1'b1;
    wait_cyc(58);
    div_sel = 4'd0;
    wait_cyc(79);
    locked = 1'b0;
    wait_cyc(80);
    locked = 1'b1;
    wait_cyc(90);
    div_sel = 4'd15;
    wait_cyc(r + 64);

    #2 resetn = 1'b0;
    #1;
    chk("async_div_clk", div_clk, 0);
    chk("async_div_rise", div_rise, 0);
    chk("async_rstn_out", rstn_out, 0);
    chk("async_cur_div", cur_div, 7);
    chk("segA_clk_left", clk_q.size(), 0);
    chk("segA_rst_left", rst_q.size(), 0);
    clk_q.delete();
    rst_q.delete();

    div_sel = 4'd1;
    repeat (3) @(negedge clk);
    for (int c = 8; c < 28; c += 4) begin
      push_clk(c, 1'b1, 1);
      push_clk(c + 2, 1'b0, 1);
    end
    push_clk(28, 1'b1, 1);
    push_rst(21, 1'b1);
    #2 resetn = 1'b1;
    wait_cyc(29);
    #2;
    chk("segB_clk_left", clk_q.size(), 0);
    chk("segB_rst_left", rst_q.size(), 0);
    chk("segB_rstn_held", rstn_out, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
